commit_alloc_ring: RTL and testbench
====================================

Name: commit_alloc_ring

Overview:
- Allocates commit-station entries to the rename stage and tracks which entries are live.
- Sits between the rename controller and the commit unit as a circular allocator over NCOMMIT commit stations.
- Provides next_start (base index for this cycle's renamed instructions) and current_available (free-entry count) to rename.
- Absorbs per-cycle allocation counts from rename, retirement counts from commit, and branch/trap flushes that truncate the tail.

Parameters:
NCOMMIT, 32, number of commit stations; must equal 2**LNCOMMIT
LNCOMMIT, 5, bits to index a commit station
NDEC, 4, decode width; max allocation per cycle is 2*NDEC
NRETIRE, 8, max entries retired per cycle

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
alloc_count  input  LNCOMMIT  entries allocated this cycle (rename count_out, 0..2*NDEC)
retire_count  input  $clog2(NRETIRE)+1  entries retired this cycle from the head (0..NRETIRE)
flush_valid  input  1  branch mispredict or trap flush
flush_addr  input  LNCOMMIT  index of flushing entry; it is kept, all younger entries are freed
next_start  output  LNCOMMIT  index of next entry to allocate (tail)
current_start  output  LNCOMMIT  index of oldest live entry (head)
current_available  output  LNCOMMIT+1  free entries, NCOMMIT-count
live  output  NCOMMIT  one bit per station, 1 = allocated
empty  output  1  count==0
full  output  1  count==NCOMMIT
err  output  1  sticky protocol-violation flag

Behaviour:
- State: head[LNCOMMIT-1:0], tail[LNCOMMIT-1:0], count[LNCOMMIT:0], live vector, err.
- All outputs are decoded from registers only, with no combinational path from inputs. This avoids loops with rename's stall compare.
- Pointer arithmetic is modulo NCOMMIT (natural LNCOMMIT-bit wrap).
- Reset: head=0, tail=0, count=0, live=0, err=0. Outputs: next_start=0, current_start=0, current_available=NCOMMIT, empty=1, full=0.
- Retire (every non-reset cycle), with r=retire_count:
  - If r<=count: clear live[head..head+r-1] (wrapping), head+=r, count-=r.
  - If r>count: retire only count entries, set err.
- Allocate (only when flush_valid=0), with a=alloc_count:
  - Legality is checked against the pre-retire free count NCOMMIT-count, i.e. the registered current_available rename saw.
  - If legal: set live[tail..tail+a-1], tail+=a, count+=a (net of retire).
  - If a>NCOMMIT-count: ignore the allocation, set err.
- Flush (flush_valid=1):
  - alloc_count is ignored that cycle.
  - flush_addr must be live, else ignore the flush and set err.
  - Set tail=flush_addr+1 and clear live bits for entries strictly younger than flush_addr.
  - Kept = ((flush_addr-head) mod NCOMMIT)+1. New count = kept-r.
  - If r>kept: clamp retire to kept (ring becomes empty, head=tail), set err.
- Priority when simultaneous: reset > flush > allocate; retire always combines with whichever applies.
- Latency: alloc/retire/flush effects are visible on all outputs the cycle after the input.
- Full wrap: with count==NCOMMIT, head==tail; empty and full are distinguished only by count.
- err clears only on reset.

Test Plan:
1. Reset, then alloc_count=8 for 3 cycles -> next_start 8,16,24; current_available 24,16,8; live=0x00FFFFFF; empty=0.
2. From state 1, alloc 8 with retire_count=8 in the same cycle -> next_start=0 (wrap), current_start=8, count stays 24, live=0xFFFFFF00, err=0.
3. Fill to 32 -> full=1, current_available=0, next_start==current_start. Next alloc_count=2 -> ignored, err=1.
4. head=0, count=20, flush_addr=5 with alloc_count=4 -> next_start=6, count=6, live=0x3F, allocation ignored.
5. head=30, count=10 (entries 30..7), flush_addr=1, retire_count=2 -> head=0, tail=2, count=2, live=0x3, err=0.
6. Flush with flush_addr not live (head=0, count=4, flush_addr=10) -> state unchanged except retire, err=1. Reset mid-operation -> all reset values next cycle.

Source files
------------

// File: rtl/commit_alloc_ring_if.sv
// Rename/commit handshake bundle for the commit-station allocator ring.
// The master drives counts and flushes. The slave (the ring) drives the pointer and occupancy view.
interface commit_alloc_ring_if #(
   parameter int NCOMMIT  = 32,
   parameter int LNCOMMIT = 5,
   parameter int NRETIRE  = 8
) ();
   logic [LNCOMMIT-1:0]        alloc_count;
   logic [$clog2(NRETIRE):0]   retire_count;
   logic                       flush_valid;
   logic [LNCOMMIT-1:0]        flush_addr;
   logic [LNCOMMIT-1:0]        next_start;
   logic [LNCOMMIT-1:0]        current_start;
   logic [LNCOMMIT:0]          current_available;
   logic [NCOMMIT-1:0]         live;
   logic                       empty;
   logic                       full;
   logic                       err;

   modport master (
      output alloc_count, retire_count, flush_valid, flush_addr,
      input  next_start, current_start, current_available, live, empty, full, err
   );

   modport slave (
      input  alloc_count, retire_count, flush_valid, flush_addr,
      output next_start, current_start, current_available, live, empty, full, err
   );
endinterface

// File: rtl/commit_alloc_ring.sv
// Circular allocator over NCOMMIT commit stations. It tracks head/tail/count and the live bits, with flush truncation.
// Effects appear one cycle after the inputs. Outputs decode registers only, so rename's stall compare sees no input-to-output path.
module commit_alloc_ring #(
   parameter int NCOMMIT  = 32,
   parameter int LNCOMMIT = 5,
   parameter int NDEC     = 4,
   parameter int NRETIRE  = 8
) (
   input  logic               clk,
   input  logic               reset,
   commit_alloc_ring_if.slave ring
);
   localparam int CW = LNCOMMIT + 1;
   localparam logic [CW-1:0] NC = CW'(NCOMMIT);

   logic [LNCOMMIT-1:0] head_q, head_d;
   logic [LNCOMMIT-1:0] tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic [NCOMMIT-1:0]  live_q, live_d;
   logic                err_q, err_d;

   logic [CW-1:0]       free_cnt, a_ext, r_ext, kept, lim, ext, r_eff;
   logic [LNCOMMIT-1:0] fl_off, off;
   logic                flush_ok, alloc_ok;

   always_comb begin
      free_cnt = NC - count_q;
      a_ext    = CW'(ring.alloc_count);
      r_ext    = CW'(ring.retire_count);
      flush_ok = ring.flush_valid && live_q[ring.flush_addr];
      alloc_ok = !ring.flush_valid && (a_ext <= free_cnt);
      fl_off   = ring.flush_addr - head_q;
      kept     = {1'b0, fl_off} + CW'(1);

      // ext = occupancy after alloc/flush, before retire.
      // lim = how far retire may reach into the pre-cycle ring.
      ext    = count_q;
      lim    = count_q;
      tail_d = tail_q;
      err_d  = err_q;
      if (ring.flush_valid) begin
         if (flush_ok) begin
            ext    = kept;
            lim    = kept;
            tail_d = ring.flush_addr + LNCOMMIT'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (alloc_ok) begin
         ext    = count_q + a_ext;
         tail_d = tail_q + ring.alloc_count;
      end else begin
         err_d = 1'b1;
      end

      if (r_ext > lim) begin
         r_eff = lim;
         err_d = 1'b1;
      end else begin
         r_eff = r_ext;
      end

      head_d  = head_q + r_eff[LNCOMMIT-1:0];
      count_d = ext - r_eff;

      // Live entries form one contiguous run starting at the head, so each bit is its age offset tested against that run.
      off    = '0;
      live_d = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
         off       = LNCOMMIT'(i) - head_q;
         live_d[i] = ({1'b0, off} >= r_eff) && ({1'b0, off} < ext);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         live_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         live_q  <= live_d;
         err_q   <= err_d;
      end
   end

   assign ring.next_start        = tail_q;
   assign ring.current_start     = head_q;
   assign ring.current_available = NC - count_q;
   assign ring.live              = live_q;
   assign ring.empty             = (count_q == '0);
   assign ring.full              = (count_q == NC);
   assign ring.err               = err_q;
endmodule

// File: tb/tb_commit_alloc_ring.sv
// Randomized plus directed bench for commit_alloc_ring against a queue-based occupancy model.
module tb_commit_alloc_ring;
   localparam int N  = 32;
   localparam int LN = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   commit_alloc_ring_if #(.NCOMMIT(N), .LNCOMMIT(LN), .NRETIRE(8)) ring_if ();

   commit_alloc_ring #(.NCOMMIT(N), .LNCOMMIT(LN), .NDEC(4), .NRETIRE(8)) dut (
      .clk   (clk),
      .reset (reset),
      .ring  (ring_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: a queue of live station indices, oldest first.
   int q[$];
   int m_head;
   bit m_err;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_head = 0;
      m_err  = 1'b0;
   endtask

   task automatic model_cycle(input int a, input int r, input bit fv, input int fa);
      int pre, lim, idx;
      pre = q.size();
      lim = pre;
      if (fv) begin
         idx = -1;
         foreach (q[k]) if (q[k] == fa) idx = k;
         if (idx < 0) m_err = 1'b1;
         else begin
            while (q.size() > idx + 1) void'(q.pop_back());
            lim = idx + 1;
         end
      end else if (a > N - pre) begin
         m_err = 1'b1;
      end else begin
         for (int k = 0; k < a; k++) q.push_back((m_head + q.size()) % N);
      end
      if (r > lim) begin
         m_err = 1'b1;
         r = lim;
      end
      for (int k = 0; k < r; k++) begin
         void'(q.pop_front());
         m_head = (m_head + 1) % N;
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] lv;
      lv = '0;
      foreach (q[k]) lv[q[k]] = 1'b1;
      check_eq({tag, ".next_start"}, 64'(ring_if.next_start), 64'((m_head + q.size()) % N));
      check_eq({tag, ".current_start"}, 64'(ring_if.current_start), 64'(m_head));
      check_eq({tag, ".avail"}, 64'(ring_if.current_available), 64'(N - q.size()));
      check_eq({tag, ".live"}, 64'(ring_if.live), 64'(lv));
      check_eq({tag, ".empty"}, 64'(ring_if.empty), 64'(q.size() == 0));
      check_eq({tag, ".full"}, 64'(ring_if.full), 64'(q.size() == N));
      check_eq({tag, ".err"}, 64'(ring_if.err), 64'(m_err));
   endtask

   task automatic drive(input int a, input int r, input bit fv, input int fa);
      ring_if.alloc_count  = LN'(a);
      ring_if.retire_count = 4'(r);
      ring_if.flush_valid  = fv;
      ring_if.flush_addr   = LN'(fa);
   endtask

   task automatic step(input int a, input int r, input bit fv, input int fa);
      drive(a, r, fv, fa);
      @(posedge clk);
      model_cycle(a, r, fv, fa);
      #1;
      check_all("step");
   endtask

   task automatic do_reset(input int a, input int r, input bit fv, input int fa);
      drive(a, r, fv, fa);
      reset = 1'b1;
      @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;
      check_all("reset");
   endtask

   initial begin
      int a, r, fa, free_n;
      bit fv;
      reset = 1'b1;
      drive(0, 0, 1'b0, 0);
      model_reset();

      // Plan 1/2/3: fill in 8s, wrap, then overfill.
      do_reset(0, 0, 1'b0, 0);
      check_eq("t1.avail_rst", 64'(ring_if.current_available), 64'd32);
      check_eq("t1.empty_rst", 64'(ring_if.empty), 64'd1);
      for (int k = 0; k < 3; k++) step(8, 0, 1'b0, 0);
      check_eq("t1.next_start", 64'(ring_if.next_start), 64'd24);
      check_eq("t1.live", 64'(ring_if.live), 64'h00FF_FFFF);
      step(8, 8, 1'b0, 0);
      check_eq("t2.next_start", 64'(ring_if.next_start), 64'd0);
      check_eq("t2.current_start", 64'(ring_if.current_start), 64'd8);
      check_eq("t2.live", 64'(ring_if.live), 64'hFFFF_FF00);
      check_eq("t2.err", 64'(ring_if.err), 64'd0);
      step(8, 0, 1'b0, 0);
      check_eq("t3.full", 64'(ring_if.full), 64'd1);
      check_eq("t3.wrap", 64'(ring_if.next_start), 64'(ring_if.current_start));
      step(2, 0, 1'b0, 0);
      check_eq("t3.err", 64'(ring_if.err), 64'd1);

      // Plan 4: flush wins over a simultaneous allocation.
      do_reset(0, 0, 1'b0, 0);
      step(8, 0, 1'b0, 0); step(8, 0, 1'b0, 0); step(4, 0, 1'b0, 0);
      step(4, 0, 1'b1, 5);
      check_eq("t4.next_start", 64'(ring_if.next_start), 64'd6);
      check_eq("t4.live", 64'(ring_if.live), 64'h3F);

      // Plan 5: flush plus retire across the wrap point.
      do_reset(0, 0, 1'b0, 0);
      for (int k = 0; k < 3; k++) step(8, 0, 1'b0, 0);
      step(6, 0, 1'b0, 0);
      for (int k = 0; k < 3; k++) step(0, 8, 1'b0, 0);
      step(0, 6, 1'b0, 0);
      step(8, 0, 1'b0, 0); step(2, 0, 1'b0, 0);
      step(0, 2, 1'b1, 1);
      check_eq("t5.head", 64'(ring_if.current_start), 64'd0);
      check_eq("t5.tail", 64'(ring_if.next_start), 64'd2);
      check_eq("t5.live", 64'(ring_if.live), 64'h3);
      check_eq("t5.err", 64'(ring_if.err), 64'd0);

      // Plan 6: a flush of a non-live entry still retires, and reset with inputs active.
      do_reset(0, 0, 1'b0, 0);
      step(4, 0, 1'b0, 0);
      step(0, 1, 1'b1, 10);
      check_eq("t6.err", 64'(ring_if.err), 64'd1);
      check_eq("t6.live", 64'(ring_if.live), 64'hE);
      do_reset(5, 3, 1'b0, 0);
      check_eq("t6.rst_avail", 64'(ring_if.current_available), 64'd32);

      // Randomized traffic, mostly legal, with periodic resets so err is exercised both ways.
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 249) begin
            do_reset(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), 1'b0, 0);
            continue;
         end
         free_n = N - q.size();
         if ($urandom_range(0, 99) < 88) a = int'($urandom_range(0, (free_n < 8) ? free_n : 8));
         else a = int'($urandom_range(0, 12));
         if ($urandom_range(0, 99) < 90) r = int'($urandom_range(0, (q.size() < 8) ? q.size() : 8));
         else r = int'($urandom_range(0, 9));
         fv = ($urandom_range(0, 99) < 12);
         if (fv && q.size() > 0 && $urandom_range(0, 9) < 8)
            fa = q[$urandom_range(0, q.size() - 1)];
         else
            fa = int'($urandom_range(0, N - 1));
         step(a, r, fv, fa);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
